// File: rtl/light_sched.sv
// light_sched: round-robin scheduler sharing the green/yellow/red light inputs between consoles.
// Ports: clock/reset_n (sync, active-low); req, color_req, dur_req per console; cheat_in override;
//        grant/done one-hot per console; aborted pulse; active_id; green/yellow/red; busy.
// Optional feature: define LIGHT_SCHED_OVERRIDE_EN to let cheat_in force red (OVR state).
module light_sched #(
    parameter int NREQ = 2,
    parameter int DW   = 6,
    parameter int GAP  = 1
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic [NREQ-1:0]    req,
    input  logic [2*NREQ-1:0]  color_req,
    input  logic [DW*NREQ-1:0] dur_req,
    input  logic               cheat_in,
    output logic [NREQ-1:0]    grant,
    output logic [NREQ-1:0]    done,
    output logic               aborted,
    output logic [1:0]         active_id,
    output logic               green,
    output logic               yellow,
    output logic               red,
    output logic               busy
);
`ifdef LIGHT_SCHED_OVERRIDE_EN
    typedef enum logic [1:0] {S_IDLE, S_HOLD, S_GAP, S_OVR} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_HOLD, S_GAP} state_t;
    logic unused_cheat;
    assign unused_cheat = cheat_in;
`endif
    state_t          state_q, state_d;
    logic [1:0]      rr_q, rr_d, id_q, id_d, col_q, col_d, nxt;
    logic [DW-1:0]   cnt_q, cnt_d, dur;
    logic [3:0]      gcnt_q, gcnt_d;
    logic [NREQ-1:0] grant_q, grant_d, done_q, done_d, one;
    logic [2:0]      lights_q, lights_d;
    logic            aborted_q, aborted_d, busy_q, busy_d, found;
    int              sel, idx;

    assign one = NREQ'(1);

    always_comb begin
        found = 1'b0;
        sel = 0;
        idx = 0;
        // first requester at or after the round-robin pointer, wrapping
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(rr_q) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            if (!found && 1'(req >> idx)) begin
                found = 1'b1;
                sel = idx;
            end
        end
        dur = DW'(dur_req >> (DW * sel));
        nxt = (id_q == 2'(NREQ - 1)) ? 2'd0 : id_q + 2'd1;
        state_d = state_q;
        rr_d = rr_q;
        id_d = id_q;
        col_d = col_q;
        cnt_d = cnt_q;
        gcnt_d = gcnt_q;
        done_d = '0;
        aborted_d = 1'b0;
        case (state_q)
            S_IDLE: if (found) begin
                state_d = S_HOLD;
                id_d = 2'(sel);
                col_d = 2'(color_req >> (2 * sel));
                cnt_d = (dur == '0) ? DW'(1) : dur;
            end
            S_HOLD: if (cnt_q == DW'(1)) begin
                state_d = S_GAP;
                gcnt_d = 4'(GAP);
                done_d = one << id_q;
                rr_d = nxt;
            end else begin
                cnt_d = cnt_q - DW'(1);
            end
            S_GAP: if (gcnt_q == 4'd1) state_d = S_IDLE;
                   else gcnt_d = gcnt_q - 4'd1;
`ifdef LIGHT_SCHED_OVERRIDE_EN
            S_OVR: if (!cheat_in) begin
                state_d = S_GAP;
                gcnt_d = 4'(GAP);
            end
`endif
            default: state_d = S_IDLE;
        endcase
`ifdef LIGHT_SCHED_OVERRIDE_EN
        // override wins over a same-cycle grant; an interrupted owner is released and skipped
        if (cheat_in) begin
            state_d = S_OVR;
            id_d = id_q;
            if (state_q == S_HOLD) begin
                done_d = one << id_q;
                aborted_d = 1'b1;
                rr_d = nxt;
            end
        end
`endif
        grant_d = (state_d == S_HOLD) ? one << id_d : '0;
        lights_d = (state_d != S_HOLD || col_d == 2'b00) ? 3'b000 : 3'b001 << (col_d - 2'd1);
`ifdef LIGHT_SCHED_OVERRIDE_EN
        if (state_d == S_OVR) lights_d = 3'b100;
`endif
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            rr_q      <= '0;
            id_q      <= '0;
            col_q     <= '0;
            cnt_q     <= '0;
            gcnt_q    <= '0;
            grant_q   <= '0;
            done_q    <= '0;
            aborted_q <= 1'b0;
            lights_q  <= '0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            rr_q      <= rr_d;
            id_q      <= id_d;
            col_q     <= col_d;
            cnt_q     <= cnt_d;
            gcnt_q    <= gcnt_d;
            grant_q   <= grant_d;
            done_q    <= done_d;
            aborted_q <= aborted_d;
            lights_q  <= lights_d;
            busy_q    <= busy_d;
        end
    end

    assign grant     = grant_q;
    assign done      = done_q;
    assign aborted   = aborted_q;
    assign active_id = id_q;
    assign {red, yellow, green} = lights_q;
    assign busy      = busy_q;
endmodule

// File: tb/tb_light_sched.sv
// tb_light_sched: randomized and directed checks of light_sched against a schedule-level model.
module tb_light_sched;
    localparam int NREQ = 2;
    localparam int DW   = 6;
    localparam int GAP  = 1;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        cheat_in = 1'b0;
    logic [1:0]  req = '0;
    logic [3:0]  color_req = '0;
    logic [11:0] dur_req = '0;
    logic [1:0]  grant, done, active_id;
    logic        aborted, green, yellow, red, busy;
    logic [10:0] obs, exp;
    int          n_assert = 0;
    int          n_fail = 0;

    logic [1:0] e_grant [0:63];
    logic [1:0] e_done  [0:63];
    logic [1:0] e_id    [0:63];
    logic [2:0] e_light [0:63];
    logic       e_busy  [0:63];

    always #5 clock = ~clock;

    assign obs = {grant, done, aborted, active_id, red, yellow, green, busy};

    light_sched #(.NREQ(NREQ), .DW(DW), .GAP(GAP)) dut (
        .clock(clock), .reset_n(reset_n), .req(req), .color_req(color_req),
        .dur_req(dur_req), .cheat_in(cheat_in), .grant(grant), .done(done),
        .aborted(aborted), .active_id(active_id), .green(green), .yellow(yellow),
        .red(red), .busy(busy)
    );

    function automatic logic [2:0] light_of(input logic [1:0] c);
        case (c)
            2'b01:   return 3'b001;
            2'b10:   return 3'b010;
            2'b11:   return 3'b100;
            default: return 3'b000;
        endcase
    endfunction

    // Expected per-cycle outputs for constant requests, cycle 1 = first cycle after the sampling edge.
    // Each grant period is D hold cycles, GAP off cycles, then one idle cycle that picks the next owner.
    function automatic void build_model(input logic [1:0] m, input logic [3:0] cols,
                                        input logic [11:0] durs, input int n);
        int s, ptr, own, d;
        for (int k = 0; k <= n; k++) begin
            e_grant[k] = '0; e_done[k] = '0; e_id[k] = '0; e_light[k] = '0; e_busy[k] = 1'b0;
        end
        s = 1;
        ptr = 0;
        while (s <= n && m != 2'b00) begin
            own = (((m >> ptr) & 2'b01) != 2'b00) ? ptr : 1 - ptr;
            d = int'(durs >> (6 * own)) & 63;
            if (d == 0) d = 1;
            for (int k = s; k <= n; k++) e_id[k] = 2'(own);
            for (int k = s; k < s + d && k <= n; k++) begin
                e_grant[k] = own ? 2'b10 : 2'b01;
                e_light[k] = light_of(2'((cols >> (2 * own)) & 4'd3));
            end
            if (s + d <= n) e_done[s + d] = own ? 2'b10 : 2'b01;
            for (int k = s; k < s + d + GAP && k <= n; k++) e_busy[k] = 1'b1;
            ptr = 1 - own;
            s = s + d + GAP + 1;
        end
    endfunction

    task automatic do_reset();
        @(posedge clock);
        #1;
        reset_n = 1'b0; req = '0; cheat_in = 1'b0; color_req = '0; dur_req = '0;
        repeat (2) @(posedge clock);
        #1 reset_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        req = 2'b01; color_req = 4'b0010; dur_req = 12'd20;
        repeat (3) @(posedge clock);
        @(negedge clock);
        exp = {2'b01, 2'b00, 1'b0, 2'd0, 3'b010, 1'b1};
        n_assert++;
        if (obs !== exp) begin n_fail++; $display("FAIL reset_pre_hold: got %b want %b", obs, exp); end
        reset_n = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(posedge clock); @(negedge clock);
            n_assert++;
            if (obs !== 11'd0) begin n_fail++; $display("FAIL reset_outputs c%0d: got %b want %b", k, obs, 11'd0); end
        end
    endtask

    task automatic test_single_green();
        do_reset();
        req = 2'b01; color_req = 4'b0001; dur_req = {6'd0, 6'd5};
        for (int k = 1; k <= 8; k++) begin
            @(posedge clock); @(negedge clock);
            exp = (k <= 5) ? {2'b01, 2'b00, 1'b0, 2'd0, 3'b001, 1'b1} :
                  (k == 6) ? {2'b00, 2'b01, 1'b0, 2'd0, 3'b000, 1'b1} : 11'd0;
            n_assert++;
            if (obs !== exp) begin n_fail++; $display("FAIL single_green c%0d: got %b want %b", k, obs, exp); end
            if (k == 6) req = 2'b00;
        end
    endtask

    task automatic test_two_consoles();
        do_reset();
        req = 2'b11; color_req = {2'b11, 2'b10}; dur_req = {6'd2, 6'd3};
        build_model(req, color_req, dur_req, 30);
        for (int k = 1; k <= 30; k++) begin
            @(posedge clock); @(negedge clock);
            exp = {e_grant[k], e_done[k], 1'b0, e_id[k], e_light[k], e_busy[k]};
            n_assert++;
            if (obs !== exp) begin n_fail++; $display("FAIL two_consoles c%0d: got %b want %b", k, obs, exp); end
            n_assert++;
            if (!$onehot0({red, yellow, green})) begin
                n_fail++; $display("FAIL two_lights c%0d: got %b want at most one light", k, {red, yellow, green});
            end
        end
    endtask

    task automatic test_dur_zero();
        do_reset();
        req = 2'b10; color_req = 4'b1100; dur_req = '0;
        for (int k = 1; k <= 4; k++) begin
            @(posedge clock); @(negedge clock);
            exp = (k == 1) ? {2'b10, 2'b00, 1'b0, 2'd1, 3'b100, 1'b1} :
                  (k == 2) ? {2'b00, 2'b10, 1'b0, 2'd1, 3'b000, 1'b1} :
                             {2'b00, 2'b00, 1'b0, 2'd1, 3'b000, 1'b0};
            n_assert++;
            if (obs !== exp) begin n_fail++; $display("FAIL dur_zero c%0d: got %b want %b", k, obs, exp); end
            if (k == 2) req = 2'b00;
        end
    endtask

    task automatic test_reset_midhold();
        do_reset();
        req = 2'b11; color_req = {2'b10, 2'b01}; dur_req = {6'd10, 6'd2};
        for (int k = 1; k <= 11; k++) begin
            @(posedge clock); @(negedge clock);
            exp = (k <= 2)  ? {2'b01, 2'b00, 1'b0, 2'd0, 3'b001, 1'b1} :
                  (k == 3)  ? {2'b00, 2'b01, 1'b0, 2'd0, 3'b000, 1'b1} :
                  (k == 4)  ? 11'd0 :
                  (k <= 8)  ? {2'b10, 2'b00, 1'b0, 2'd1, 3'b010, 1'b1} :
                  (k == 9)  ? 11'd0 :
                              {2'b01, 2'b00, 1'b0, 2'd0, 3'b001, 1'b1};
            n_assert++;
            if (obs !== exp) begin n_fail++; $display("FAIL reset_midhold c%0d: got %b want %b", k, obs, exp); end
            if (k == 8) reset_n = 1'b0;
            if (k == 9) reset_n = 1'b1;
        end
    endtask

    task automatic test_override();
        do_reset();
        req = 2'b11; color_req = {2'b11, 2'b01}; dur_req = {6'd2, 6'd8};
        for (int k = 1; k <= 11; k++) begin
            @(posedge clock); @(negedge clock);
`ifdef LIGHT_SCHED_OVERRIDE_EN
            exp = (k <= 3)  ? {2'b01, 2'b00, 1'b0, 2'd0, 3'b001, 1'b1} :
                  (k == 4)  ? {2'b00, 2'b01, 1'b1, 2'd0, 3'b100, 1'b1} :
                  (k <= 7)  ? {2'b00, 2'b00, 1'b0, 2'd0, 3'b100, 1'b1} :
                  (k == 8)  ? {2'b00, 2'b00, 1'b0, 2'd0, 3'b000, 1'b1} :
                  (k == 9)  ? 11'd0 :
                              {2'b10, 2'b00, 1'b0, 2'd1, 3'b100, 1'b1};
`else
            exp = (k <= 8)  ? {2'b01, 2'b00, 1'b0, 2'd0, 3'b001, 1'b1} :
                  (k == 9)  ? {2'b00, 2'b01, 1'b0, 2'd0, 3'b000, 1'b1} :
                  (k == 10) ? 11'd0 :
                              {2'b10, 2'b00, 1'b0, 2'd1, 3'b100, 1'b1};
`endif
            n_assert++;
            if (obs !== exp) begin n_fail++; $display("FAIL override c%0d: got %b want %b", k, obs, exp); end
            if (k == 3) cheat_in = 1'b1;
            if (k == 7) cheat_in = 1'b0;
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 8; it++) begin
            do_reset();
            req = 2'($urandom_range(0, 3));
            color_req = 4'($urandom);
            dur_req = {6'($urandom_range(0, 9)), 6'($urandom_range(0, 9))};
            build_model(req, color_req, dur_req, 40);
            for (int k = 1; k <= 40; k++) begin
                @(posedge clock); @(negedge clock);
                exp = {e_grant[k], e_done[k], 1'b0, e_id[k], e_light[k], e_busy[k]};
                n_assert++;
                if (obs !== exp) begin
                    n_fail++;
                    $display("FAIL random i%0d c%0d req=%b col=%b dur=%h: got %b want %b",
                             it, k, req, color_req, dur_req, obs, exp);
                end
                n_assert++;
                if (!$onehot0({red, yellow, green})) begin
                    n_fail++; $display("FAIL random_lights i%0d c%0d: got %b want at most one light", it, k, {red, yellow, green});
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_green();
        test_two_consoles();
        test_dur_zero();
        test_reset_midhold();
        test_override();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
